// File: rtl/lsb_ring_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsb_ring_pkg
//  Description : Shared definitions for the lsb_ring load/store buffer:
//                memory op encodings, store classification helper, default
//                ROB tag width, MMIO region tag and head FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsb_ring_pkg;

   localparam int ROB_W_DEF = 4;

   // addr[17:16] value that marks the I/O region
   localparam logic [1:0] MMIO_REGION = 2'b11;

   // bit3 distinguishes stores from loads
   typedef enum logic [3:0] {
      OP_LB  = 4'b0000,
      OP_LH  = 4'b0001,
      OP_LW  = 4'b0010,
      OP_LBU = 4'b0100,
      OP_LHU = 4'b0101,
      OP_SB  = 4'b1000,
      OP_SH  = 4'b1001,
      OP_SW  = 4'b1010
   } mem_op_e;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_WAIT_MEM = 1'b1
   } head_state_e;

   function automatic logic is_store(input logic [3:0] op);
      return (op & 4'b1000) != 4'b0000;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsb_cdb_snoop.sv
`default_nettype none
// ============================================================================
//  Module      : lsb_cdb_snoop
//  Description : Compares one producer tag against CDB_NUM result buses and
//                returns a hit flag plus the value of the matching bus. When
//                several buses match, the lowest bus index wins.
//  Ports       : tag_i        - producer tag being waited on
//                cdb_valid_i  - per-bus valid
//                cdb_rob_i    - concatenated bus tags (bus b at [b*ROB_W +: ROB_W])
//                cdb_value_i  - concatenated bus values (bus b at [b*32 +: 32])
//                hit_o        - some valid bus carries tag_i
//                value_o      - value of the selected bus (0 when no hit)
//  Revision    : 1.0 - initial release
// ============================================================================
module lsb_cdb_snoop
   import lsb_ring_pkg::*;
#(
   parameter int CDB_NUM = 2,
   parameter int ROB_W   = ROB_W_DEF
) (
   input  logic [ROB_W-1:0]         tag_i,
   input  logic [CDB_NUM-1:0]       cdb_valid_i,
   input  logic [CDB_NUM*ROB_W-1:0] cdb_rob_i,
   input  logic [CDB_NUM*32-1:0]    cdb_value_i,
   output logic                     hit_o,
   output logic [31:0]              value_o
);

   // Scan from the highest bus down so the lowest matching index is the
   // last assignment and therefore wins.
   always_comb begin
      hit_o   = 1'b0;
      value_o = '0;
      for (int b = CDB_NUM - 1; b >= 0; b--) begin
         if (cdb_valid_i[b] && (cdb_rob_i[b*ROB_W +: ROB_W] == tag_i)) begin
            hit_o   = 1'b1;
            value_o = cdb_value_i[b*32 +: 32];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/lsb_ring.sv
`default_nettype none
// ============================================================================
//  Module      : lsb_ring
//  Description : Parametrised in-order load/store buffer. Entries live in a
//                power-of-two ring; operands wake up by snooping CDB_NUM
//                result buses; the head entry performs one memory access at a
//                time. Load results and store readiness are broadcast to the
//                ROB. ROB-committed stores survive a flush.
//  Ports       : clk_in/rst_n_in         - clock, async active-low reset
//                rdy_in                  - global stall (low = hold state)
//                flush_in                - mispredict clear
//                full_out                - ring holds DEPTH entries
//                disp_*                  - dispatch from the decoder
//                cdb_*                   - snooped result buses
//                commit_store, rob_head  - ROB commit / head tag
//                mem_*                   - memory controller handshake
//                out_*                   - result broadcast to the ROB
//  Options     : LSB_MMIO_GUARD_EN - hold loads to addr[17:16]==2'b11 until
//                their tag is at the ROB head and no flush is active.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsb_ring
   import lsb_ring_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int ROB_W   = ROB_W_DEF,
   parameter int CDB_NUM = 2
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic                     rdy_in,
   input  logic                     flush_in,
   output logic                     full_out,
   input  logic                     disp_valid,
   input  logic [3:0]               disp_op,
   input  logic [31:0]              disp_base,
   input  logic [31:0]              disp_data,
   input  logic                     disp_base_dep,
   input  logic                     disp_data_dep,
   input  logic [ROB_W-1:0]         disp_base_q,
   input  logic [ROB_W-1:0]         disp_data_q,
   input  logic [31:0]              disp_imm,
   input  logic [ROB_W-1:0]         disp_rob,
   input  logic [CDB_NUM-1:0]       cdb_valid,
   input  logic [CDB_NUM*ROB_W-1:0] cdb_rob,
   input  logic [CDB_NUM*32-1:0]    cdb_value,
   input  logic                     commit_store,
   input  logic [ROB_W-1:0]         rob_head,
   output logic                     mem_req,
   output logic [3:0]               mem_op,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_wdata,
   input  logic                     mem_done,
   input  logic [31:0]              mem_rdata,
   output logic                     out_valid,
   output logic [ROB_W-1:0]         out_rob,
   output logic [31:0]              out_value
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // ---------------- entry storage ----------------
   logic [DEPTH-1:0] valid_q, db_q, dd_q, committed_q, reported_q;
   logic [3:0]       op_q  [DEPTH];
   logic [31:0]      vb_q  [DEPTH];
   logic [31:0]      vd_q  [DEPTH];
   logic [31:0]      imm_q [DEPTH];
   logic [ROB_W-1:0] qb_q  [DEPTH];
   logic [ROB_W-1:0] qd_q  [DEPTH];
   logic [ROB_W-1:0] rob_q [DEPTH];

   logic [PTR_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q;

   head_state_e state_q, state_d;
   logic        discard_q, discard_d;   // in-flight load was flushed

   logic             mem_req_q, out_valid_q;
   logic [3:0]       mem_op_q;
   logic [31:0]      mem_addr_q, mem_wdata_q, out_value_q;
   logic [ROB_W-1:0] out_rob_q;

   // ---------------- CDB snooping ----------------
   logic [DEPTH-1:0] b_hit, d_hit;
   logic [31:0]      b_val [DEPTH];
   logic [31:0]      d_val [DEPTH];
   logic             disp_b_hit, disp_d_hit;
   logic [31:0]      disp_b_val, disp_d_val;

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_entry_snoop
         lsb_cdb_snoop #(.CDB_NUM(CDB_NUM), .ROB_W(ROB_W)) u_snoop_b (
            .tag_i(qb_q[i]), .cdb_valid_i(cdb_valid), .cdb_rob_i(cdb_rob),
            .cdb_value_i(cdb_value), .hit_o(b_hit[i]), .value_o(b_val[i]));
         lsb_cdb_snoop #(.CDB_NUM(CDB_NUM), .ROB_W(ROB_W)) u_snoop_d (
            .tag_i(qd_q[i]), .cdb_valid_i(cdb_valid), .cdb_rob_i(cdb_rob),
            .cdb_value_i(cdb_value), .hit_o(d_hit[i]), .value_o(d_val[i]));
      end
   endgenerate

   lsb_cdb_snoop #(.CDB_NUM(CDB_NUM), .ROB_W(ROB_W)) u_snoop_disp_b (
      .tag_i(disp_base_q), .cdb_valid_i(cdb_valid), .cdb_rob_i(cdb_rob),
      .cdb_value_i(cdb_value), .hit_o(disp_b_hit), .value_o(disp_b_val));
   lsb_cdb_snoop #(.CDB_NUM(CDB_NUM), .ROB_W(ROB_W)) u_snoop_disp_d (
      .tag_i(disp_data_q), .cdb_valid_i(cdb_valid), .cdb_rob_i(cdb_rob),
      .cdb_value_i(cdb_value), .hit_o(disp_d_hit), .value_o(disp_d_val));

   // ---------------- head evaluation ----------------
   logic        head_store, ld_ok, st_ok, report, mmio_ok;
   logic [31:0] head_addr;

   assign head_store = is_store(op_q[head_q]);
   assign head_addr  = vb_q[head_q] + imm_q[head_q];

`ifdef LSB_MMIO_GUARD_EN
   // I/O loads have side effects: only issue once non-speculative.
   assign mmio_ok = (head_addr[17:16] != MMIO_REGION) || (rob_q[head_q] == rob_head);
`else
   logic w_unused_guard;
   assign w_unused_guard = ^{rob_head, MMIO_REGION};
   assign mmio_ok        = 1'b1;
`endif

   assign ld_ok = valid_q[head_q] && !head_store && !db_q[head_q] && mmio_ok;
   assign st_ok = valid_q[head_q] && head_store && committed_q[head_q]
                  && !db_q[head_q] && !dd_q[head_q];
   // A committed store is already known ready by the ROB, so it is never
   // reported (this matters for stores that reach the head after a flush).
   assign report = !flush_in && valid_q[head_q] && head_store && !db_q[head_q]
                   && !dd_q[head_q] && !reported_q[head_q] && !committed_q[head_q];

   // ---------------- head FSM ----------------
   logic issue, pop, ld_done;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= ST_IDLE;
         discard_q <= 1'b0;
      end else if (rdy_in) begin
         state_q   <= state_d;
         discard_q <= discard_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      discard_d = discard_q;
      issue     = 1'b0;
      pop       = 1'b0;
      ld_done   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!flush_in && (ld_ok || st_ok)) begin
               issue   = 1'b1;
               state_d = ST_WAIT_MEM;
            end
         end
         ST_WAIT_MEM: begin
            if (mem_done) begin
               state_d   = ST_IDLE;
               discard_d = 1'b0;
               // A flushed load has already left the ring; only finish it.
               if (!discard_q) begin
                  pop     = 1'b1;
                  ld_done = !head_store && !flush_in;
               end
            end else if (flush_in && !discard_q && !head_store) begin
               discard_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- commit / flush selection ----------------
   logic [DEPTH-1:0] commit_sel, survive;
   logic [PTR_W-1:0] idx_c, idx_s, flush_k;
   logic [CNT_W-1:0] nsurv;
   logic             found_c, found_s;

   // Oldest valid uncommitted store, searched in age order from head.
   always_comb begin
      commit_sel = '0;
      found_c    = 1'b0;
      idx_c      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx_c = head_q + PTR_W'(i);
         if (commit_store && !found_c && valid_q[idx_c] && is_store(op_q[idx_c])
             && !committed_q[idx_c]) begin
            commit_sel[idx_c] = 1'b1;
            found_c           = 1'b1;
         end
      end
   end

   // Flush keeps committed stores. The run of survivors may start after an
   // uncommitted in-flight head load, so the new head is the oldest survivor.
   always_comb begin
      survive = '0;
      nsurv   = '0;
      flush_k = '0;
      found_s = 1'b0;
      idx_s   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         survive[i] = valid_q[i] && (committed_q[i] || commit_sel[i])
                      && !(pop && (head_q == PTR_W'(i)));
         nsurv      = nsurv + CNT_W'(survive[i]);
      end
      for (int i = 0; i < DEPTH; i++) begin
         idx_s = head_q + PTR_W'(i);
         if (!found_s && survive[idx_s]) begin
            flush_k = PTR_W'(i);
            found_s = 1'b1;
         end
      end
   end

   // ---------------- dispatch ----------------
   logic accept;

   assign full_out = (count_q == CNT_W'(DEPTH));
   // A slot freed by a completing access in the same cycle may be reused,
   // so a full ring still accepts when it pops.
   assign accept   = disp_valid && !flush_in && (!full_out || pop);

   // ---------------- datapath ----------------
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_op_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         out_valid_q <= 1'b0;
         out_rob_q   <= '0;
         out_value_q <= '0;
         valid_q     <= '0;
         db_q        <= '0;
         dd_q        <= '0;
         committed_q <= '0;
         reported_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i]  <= '0;
            vb_q[i]  <= '0;
            vd_q[i]  <= '0;
            imm_q[i] <= '0;
            qb_q[i]  <= '0;
            qd_q[i]  <= '0;
            rob_q[i] <= '0;
         end
      end else if (rdy_in) begin
         // memory request
         if (issue) begin
            mem_req_q   <= 1'b1;
            mem_op_q    <= op_q[head_q];
            mem_addr_q  <= head_addr;
            mem_wdata_q <= vd_q[head_q];
         end else if ((state_q == ST_WAIT_MEM) && mem_done) begin
            mem_req_q <= 1'b0;
         end

         // result broadcast
         out_valid_q <= 1'b0;
         if (ld_done) begin
            out_valid_q <= 1'b1;
            out_rob_q   <= rob_q[head_q];
            out_value_q <= mem_rdata;
         end else if (report) begin
            out_valid_q <= 1'b1;
            out_rob_q   <= rob_q[head_q];
            out_value_q <= '0;
         end

         // ring pointers
         if (flush_in) begin
            head_q  <= head_q + flush_k;
            tail_q  <= head_q + flush_k + nsurv[PTR_W-1:0];
            count_q <= nsurv;
         end else begin
            head_q  <= head_q + PTR_W'(pop);
            tail_q  <= tail_q + PTR_W'(accept);
            count_q <= count_q + CNT_W'(accept) - CNT_W'(pop);
         end

         // entries; dispatch is last so it wins over a pop of the same slot
         for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && db_q[i] && b_hit[i]) begin
               vb_q[i] <= b_val[i];
               db_q[i] <= 1'b0;
            end
            if (valid_q[i] && dd_q[i] && d_hit[i]) begin
               vd_q[i] <= d_val[i];
               dd_q[i] <= 1'b0;
            end
            if (commit_sel[i]) begin
               committed_q[i] <= 1'b1;
            end
            if (report && (head_q == PTR_W'(i))) begin
               reported_q[i] <= 1'b1;
            end
            if (pop && (head_q == PTR_W'(i))) begin
               valid_q[i] <= 1'b0;
            end
            if (flush_in) begin
               valid_q[i] <= survive[i];
            end
            if (accept && (tail_q == PTR_W'(i))) begin
               valid_q[i]     <= 1'b1;
               op_q[i]        <= disp_op;
               vb_q[i]        <= (disp_base_dep && disp_b_hit) ? disp_b_val : disp_base;
               vd_q[i]        <= (disp_data_dep && disp_d_hit) ? disp_d_val : disp_data;
               db_q[i]        <= disp_base_dep && !disp_b_hit;
               dd_q[i]        <= disp_data_dep && !disp_d_hit;
               qb_q[i]        <= disp_base_q;
               qd_q[i]        <= disp_data_q;
               imm_q[i]       <= disp_imm;
               rob_q[i]       <= disp_rob;
               committed_q[i] <= 1'b0;
               reported_q[i]  <= 1'b0;
            end
         end
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_op    = mem_op_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign out_valid = out_valid_q;
   assign out_rob   = out_rob_q;
   assign out_value = out_value_q;

endmodule
`default_nettype wire

// File: tb/tb_lsb_ring.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsb_ring
//  Description : Directed self-checking bench for lsb_ring (DEPTH=8, ROB_W=4,
//                CDB_NUM=2). Honours LSB_MMIO_GUARD_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsb_ring;
   import lsb_ring_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst_n_in, rdy_in, flush_in, full_out;
   logic        disp_valid, disp_base_dep, disp_data_dep;
   logic [3:0]  disp_op, disp_base_q, disp_data_q, disp_rob;
   logic [31:0] disp_base, disp_data, disp_imm;
   logic [1:0]  cdb_valid;
   logic [7:0]  cdb_rob;
   logic [63:0] cdb_value;
   logic        commit_store;
   logic [3:0]  rob_head;
   logic        mem_req, mem_done;
   logic [3:0]  mem_op;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        out_valid;
   logic [3:0]  out_rob;
   logic [31:0] out_value;

   int checks = 0;
   int errors = 0;
   bit out_seen;

   lsb_ring #(.DEPTH(8), .ROB_W(4), .CDB_NUM(2)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .full_out(full_out), .disp_valid(disp_valid), .disp_op(disp_op),
      .disp_base(disp_base), .disp_data(disp_data), .disp_base_dep(disp_base_dep),
      .disp_data_dep(disp_data_dep), .disp_base_q(disp_base_q), .disp_data_q(disp_data_q),
      .disp_imm(disp_imm), .disp_rob(disp_rob), .cdb_valid(cdb_valid), .cdb_rob(cdb_rob),
      .cdb_value(cdb_value), .commit_store(commit_store), .rob_head(rob_head),
      .mem_req(mem_req), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata), .out_valid(out_valid),
      .out_rob(out_rob), .out_value(out_value));

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
      if (out_valid) out_seen = 1'b1;
   endtask

   task automatic dispatch(input logic [3:0] op, input logic [31:0] base, input logic bdep,
                           input logic [3:0] bq, input logic [31:0] data, input logic ddep,
                           input logic [31:0] imm, input logic [3:0] rob);
      disp_valid = 1'b1; disp_op = op; disp_base = base; disp_base_dep = bdep;
      disp_base_q = bq; disp_data = data; disp_data_dep = ddep; disp_data_q = 4'd0;
      disp_imm = imm; disp_rob = rob;
      tick();
      disp_valid = 1'b0; disp_base_dep = 1'b0; disp_data_dep = 1'b0;
   endtask

   task automatic wait_req(input int budget, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         if (mem_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic complete(input logic [31:0] rdata);
      mem_done = 1'b1; mem_rdata = rdata;
      tick();
      mem_done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n_in = 1'b0;
      tick(); tick();
      checks++;
      if ({mem_req, mem_op, mem_addr, mem_wdata, out_valid, out_rob, out_value, full_out} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: req=%b addr=%h out_valid=%b full=%b, required all 0",
                  mem_req, mem_addr, out_valid, full_out);
      end
      rst_n_in = 1'b1;
      tick();
      checks++;
      if (dut.count_q !== 4'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d, required 0", dut.count_q);
      end
   endtask

   task automatic test_load();
      dispatch(OP_LW, 32'h100, 1'b0, 4'd0, 32'h0, 1'b0, 32'd4, 4'd5);
      checks++;
      if (mem_req !== 1'b0) begin
         errors++; $display("FAIL load_req_latency: req=%b, required 0 in eligible cycle", mem_req);
      end
      tick();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h104 || mem_op !== 4'b0010) begin
         errors++;
         $display("FAIL load_req: req=%b addr=%h op=%h, required 1/00000104/2", mem_req, mem_addr, mem_op);
      end
      complete(32'hDEADBEEF);
      checks++;
      if (out_valid !== 1'b1 || out_value !== 32'hDEADBEEF || out_rob !== 4'd5 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL load_result: valid=%b value=%h rob=%0d req=%b, required 1/deadbeef/5/0",
                  out_valid, out_value, out_rob, mem_req);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || dut.count_q !== 4'd0) begin
         errors++; $display("FAIL load_pop: valid=%b count=%0d, required 0/0", out_valid, dut.count_q);
      end
   endtask

   task automatic test_store_wakeup();
      dispatch(OP_SW, 32'h0, 1'b1, 4'd3, 32'h55, 1'b0, 32'd8, 4'd6);
      cdb_valid = 2'b10; cdb_rob = {4'd3, 4'd0}; cdb_value = {32'h200, 32'h0};
      tick();
      cdb_valid = 2'b00;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_rob !== 4'd6 || out_value !== 32'h0) begin
         errors++;
         $display("FAIL store_report: valid=%b rob=%0d value=%h, required 1/6/0", out_valid, out_rob, out_value);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || mem_req !== 1'b0) begin
         errors++; $display("FAIL store_report_once: valid=%b req=%b, required 0/0", out_valid, mem_req);
      end
      commit_store = 1'b1;
      tick();
      commit_store = 1'b0;
      tick();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h208 || mem_wdata !== 32'h55 || mem_op !== 4'b1010) begin
         errors++;
         $display("FAIL store_req: req=%b addr=%h wdata=%h op=%h, required 1/00000208/00000055/a",
                  mem_req, mem_addr, mem_wdata, mem_op);
      end
      complete(32'h0);
      checks++;
      if (out_valid !== 1'b0 || mem_req !== 1'b0 || dut.count_q !== 4'd0) begin
         errors++;
         $display("FAIL store_done: valid=%b req=%b count=%0d, required 0/0/0", out_valid, mem_req, dut.count_q);
      end
   endtask

   task automatic test_bypass();
      bit ok;
      cdb_valid = 2'b11; cdb_rob = {4'd7, 4'd7}; cdb_value = {32'h2000, 32'h1000};
      dispatch(OP_LW, 32'h0, 1'b1, 4'd7, 32'h0, 1'b0, 32'h10, 4'd1);
      cdb_valid = 2'b00;
      wait_req(4, ok);
      checks++;
      if (!ok || mem_addr !== 32'h1010) begin
         errors++; $display("FAIL bypass_addr: req_seen=%b addr=%h, required 1/00001010", ok, mem_addr);
      end
      complete(32'h77);
      checks++;
      if (out_valid !== 1'b1 || out_rob !== 4'd1 || out_value !== 32'h77) begin
         errors++;
         $display("FAIL bypass_result: valid=%b rob=%0d value=%h, required 1/1/77", out_valid, out_rob, out_value);
      end
   endtask

   task automatic test_full();
      logic [3:0]  exp_rob  [8];
      logic [31:0] exp_addr [8];
      bit ok;
      dispatch(OP_LW, 32'h10, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 4'd0);
      for (int i = 1; i < 8; i++) begin
         dispatch(OP_LW, 32'h0, 1'b1, 4'd15, 32'h0, 1'b0, 32'(i * 4), 4'(i));
         exp_rob[i-1]  = 4'(i);
         exp_addr[i-1] = 32'h80 + 32'(i * 4);
      end
      exp_rob[7]  = 4'd10;
      exp_addr[7] = 32'h40;
      checks++;
      if (full_out !== 1'b1) begin
         errors++; $display("FAIL full_flag: got %b, required 1", full_out);
      end
      dispatch(OP_LW, 32'h999, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 4'd9);
      checks++;
      if (full_out !== 1'b1 || dut.count_q !== 4'd8) begin
         errors++; $display("FAIL full_ignore: full=%b count=%0d, required 1/8", full_out, dut.count_q);
      end
      mem_done = 1'b1; mem_rdata = 32'h11;
      dispatch(OP_LW, 32'h40, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 4'd10);
      mem_done = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_rob !== 4'd0 || full_out !== 1'b1 || dut.count_q !== 4'd8) begin
         errors++;
         $display("FAIL full_pop_dispatch: valid=%b rob=%0d full=%b count=%0d, required 1/0/1/8",
                  out_valid, out_rob, full_out, dut.count_q);
      end
      cdb_valid = 2'b01; cdb_rob = {4'd0, 4'd15}; cdb_value = {32'h0, 32'h80};
      tick();
      cdb_valid = 2'b00;
      for (int j = 0; j < 8; j++) begin
         wait_req(10, ok);
         checks++;
         if (!ok || mem_addr !== exp_addr[j]) begin
            errors++;
            $display("FAIL drain_addr[%0d]: req_seen=%b addr=%h, required 1/%h", j, ok, mem_addr, exp_addr[j]);
         end
         complete(32'(j));
         checks++;
         if (out_valid !== 1'b1 || out_rob !== exp_rob[j] || out_value !== 32'(j)) begin
            errors++;
            $display("FAIL drain_result[%0d]: valid=%b rob=%0d value=%h, required 1/%0d/%h",
                     j, out_valid, out_rob, out_value, exp_rob[j], 32'(j));
         end
      end
   endtask

   task automatic test_flush();
      bit ok;
      dispatch(OP_LW, 32'h300, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 4'd1);
      dispatch(OP_SW, 32'h400, 1'b0, 4'd0, 32'hA1, 1'b0, 32'h0, 4'd2);
      dispatch(OP_SW, 32'h404, 1'b0, 4'd0, 32'hB2, 1'b0, 32'h0, 4'd3);
      dispatch(OP_LW, 32'h0, 1'b1, 4'd14, 32'h0, 1'b0, 32'h0, 4'd4);
      dispatch(OP_LW, 32'h0, 1'b1, 4'd14, 32'h0, 1'b0, 32'h0, 4'd5);
      commit_store = 1'b1;
      tick(); tick();
      commit_store = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
         errors++; $display("FAIL flush_load_inflight: req=%b addr=%h, required 1/00000300", mem_req, mem_addr);
      end
      out_seen = 1'b0;
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      checks++;
      if (dut.count_q !== 4'd2 || mem_req !== 1'b1) begin
         errors++; $display("FAIL flush_count: count=%0d req=%b, required 2/1", dut.count_q, mem_req);
      end
      complete(32'hBAD);
      for (int s = 0; s < 2; s++) begin
         wait_req(10, ok);
         checks++;
         if (!ok || mem_op !== 4'b1010 || mem_addr !== (32'h400 + 32'(s * 4))
             || mem_wdata !== (s == 0 ? 32'hA1 : 32'hB2)) begin
            errors++;
            $display("FAIL flush_store_drain[%0d]: req_seen=%b op=%h addr=%h wdata=%h", s, ok, mem_op, mem_addr, mem_wdata);
         end
         complete(32'h0);
      end
      tick(); tick();
      checks++;
      if (out_seen !== 1'b0 || dut.count_q !== 4'd0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL flush_no_result: out_seen=%b count=%0d req=%b, required 0/0/0", out_seen, dut.count_q, mem_req);
      end
   endtask

   task automatic test_mmio();
      bit ok;
      rob_head = 4'd2;
      dispatch(OP_LW, 32'h30000, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 4'd4);
      tick();
`ifdef LSB_MMIO_GUARD_EN
      tick(); tick();
      checks++;
      if (mem_req !== 1'b0) begin
         errors++; $display("FAIL mmio_hold: req=%b, required 0 while not at ROB head", mem_req);
      end
      rob_head = 4'd4;
      wait_req(4, ok);
`else
      ok = mem_req;
`endif
      checks++;
      if (ok !== 1'b1 || mem_addr !== 32'h30000) begin
         errors++; $display("FAIL mmio_issue: req=%b addr=%h, required 1/00030000", ok, mem_addr);
      end
      complete(32'h5A);
      checks++;
      if (out_valid !== 1'b1 || out_rob !== 4'd4 || out_value !== 32'h5A) begin
         errors++; $display("FAIL mmio_result: valid=%b rob=%0d value=%h, required 1/4/5a", out_valid, out_rob, out_value);
      end
      rob_head = 4'd0;
   endtask

   task automatic test_stall();
      rdy_in = 1'b0;
      dispatch(OP_LW, 32'h20, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 4'd3);
      tick();
      checks++;
      if (dut.count_q !== 4'd0 || mem_req !== 1'b0) begin
         errors++; $display("FAIL stall_hold: count=%0d req=%b, required 0/0", dut.count_q, mem_req);
      end
      rdy_in = 1'b1;
   endtask

   task automatic test_async_reset();
      bit ok;
      dispatch(OP_LW, 32'h50, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 4'd2);
      wait_req(4, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL areset_setup: req=%b, required 1", mem_req);
      end
      #2 rst_n_in = 1'b0;
      #1;
      checks++;
      if ({mem_req, mem_addr, mem_op, out_valid, out_rob, out_value, full_out} !== '0) begin
         errors++;
         $display("FAIL areset_outputs: req=%b addr=%h out_valid=%b, required all 0", mem_req, mem_addr, out_valid);
      end
      tick();
      rst_n_in = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (dut.count_q !== 4'd0 || mem_req !== 1'b0 || full_out !== 1'b0) begin
         errors++;
         $display("FAIL areset_empty: count=%0d req=%b full=%b, required 0/0/0", dut.count_q, mem_req, full_out);
      end
   endtask

   initial begin
      rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
      disp_valid = 1'b0; disp_op = 4'd0; disp_base = '0; disp_data = '0;
      disp_base_dep = 1'b0; disp_data_dep = 1'b0; disp_base_q = '0; disp_data_q = '0;
      disp_imm = '0; disp_rob = '0; cdb_valid = '0; cdb_rob = '0; cdb_value = '0;
      commit_store = 1'b0; rob_head = '0; mem_done = 1'b0; mem_rdata = '0;
      out_seen = 1'b0;

      test_reset();
      test_load();
      test_store_wakeup();
      test_bypass();
      test_full();
      test_flush();
      test_mmio();
      test_stall();
      test_async_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
